dds_bus_wr_master: RTL and testbench

// Write-initiator for the 4-bit-ID / 32-bit-data slave bus used by the DDS register slave.

---
 rtl/dds_bus_wr_master_if.sv | 28 ++
 rtl/dds_bus_wr_master.sv | 80 ++++++++
 tb/tb_dds_bus_wr_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dds_bus_wr_master_if.sv
// dds_bus_wr_master_if: write-channel bundle of the 4-bit-ID / 32-bit-data slave bus
interface dds_bus_wr_master_if;
  logic [3:0]  M_WR_ADDR_ID;
  logic [31:0] M_WR_ADDR;
  logic [7:0]  M_WR_ADDR_LEN;
  logic [1:0]  M_WR_ADDR_BURST;
  logic        M_WR_ADDR_VALID;
  logic        M_WR_ADDR_READY;
  logic [31:0] M_WR_DATA;
  logic [3:0]  M_WR_STRB;
  logic        M_WR_DATA_LAST;
  logic        M_WR_DATA_VALID;
  logic        M_WR_DATA_READY;
  logic [3:0]  M_WR_BACK_ID;
  logic [1:0]  M_WR_BACK_RESP;
  logic        M_WR_BACK_VALID;
  logic        M_WR_BACK_READY;
  modport master (
    output M_WR_ADDR_ID, M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_BURST, M_WR_ADDR_VALID,
    output M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST, M_WR_DATA_VALID, M_WR_BACK_READY,
    input  M_WR_ADDR_READY, M_WR_DATA_READY, M_WR_BACK_ID, M_WR_BACK_RESP, M_WR_BACK_VALID
  );
  modport slave (
    input  M_WR_ADDR_ID, M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_BURST, M_WR_ADDR_VALID,
    input  M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST, M_WR_DATA_VALID, M_WR_BACK_READY,
    output M_WR_ADDR_READY, M_WR_DATA_READY, M_WR_BACK_ID, M_WR_BACK_RESP, M_WR_BACK_VALID
  );
endinterface

// File: rtl/dds_bus_wr_master.sv
// dds_bus_wr_master: turns one local command plus a data stream into a single bus write burst
// Optional stall timeout enabled by defining DDS_WR_TIMEOUT_EN.
module dds_bus_wr_master #(
  parameter logic [3:0] WR_ID          = 4'h0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        cmd_fixed,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        done_valid,
  output logic [1:0]  done_resp,
  dds_bus_wr_master_if.master m
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic cmd_hs, addr_hs, beat_hs, back_hs, tmo;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end
  // Holding off while done_valid is high keeps exactly one burst outstanding.
  assign cmd_ready = state == IDLE && !done_valid;
  assign cmd_hs = cmd_valid && cmd_ready;
  assign addr_hs = m.M_WR_ADDR_VALID && m.M_WR_ADDR_READY;
  assign beat_hs = m.M_WR_DATA_VALID && m.M_WR_DATA_READY;
  assign back_hs = m.M_WR_BACK_VALID && m.M_WR_BACK_READY;
  assign m.M_WR_ADDR_ID = WR_ID;
  assign m.M_WR_STRB = 4'hF;
  assign m.M_WR_DATA = wr_data;
  assign m.M_WR_ADDR_VALID = state == ADDR;
  assign m.M_WR_DATA_VALID = state == DATA && wr_valid;
  assign m.M_WR_DATA_LAST = state == DATA && cnt == m.M_WR_ADDR_LEN;
  assign m.M_WR_BACK_READY = state == RESP;
  assign wr_ready = state == DATA && m.M_WR_DATA_READY;
`ifdef DDS_WR_TIMEOUT_EN
  logic [15:0] stall;
  assign tmo = state != IDLE && !(addr_hs || beat_hs || back_hs) && stall == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) stall <= '0;
    else stall <= (state == IDLE || addr_hs || beat_hs || back_hs) ? '0 : stall + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = tmo ? IDLE :
          cmd_hs ? ADDR :
          addr_hs ? DATA :
          beat_hs && m.M_WR_DATA_LAST ? RESP :
          back_hs ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m.M_WR_ADDR <= '0;
      m.M_WR_ADDR_LEN <= '0;
      m.M_WR_ADDR_BURST <= '0;
      cnt <= '0;
      done_valid <= 1'b0;
      done_resp <= '0;
    end else begin
      done_valid <= back_hs || tmo;
      cnt <= cmd_hs ? '0 : beat_hs ? cnt + 8'd1 : cnt;
      if (cmd_hs) begin
        m.M_WR_ADDR <= cmd_addr;
        m.M_WR_ADDR_LEN <= cmd_len;
        m.M_WR_ADDR_BURST <= {1'b0, !cmd_fixed};
      end
      if (tmo) done_resp <= 2'b11;
      else if (back_hs) done_resp <= m.M_WR_BACK_ID != WR_ID ? 2'b10 : m.M_WR_BACK_RESP;
    end
endmodule

// File: tb/tb_dds_bus_wr_master.sv
// tb_dds_bus_wr_master: randomized bursts checked against an expected-beat queue and response rule
module tb_dds_bus_wr_master;
  localparam logic [3:0] WR_ID = 4'h0;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid, cmd_ready, cmd_fixed, wr_valid, wr_ready, done_valid;
  logic [31:0] cmd_addr, wr_data;
  logic [7:0] cmd_len;
  logic [1:0] done_resp;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  dds_bus_wr_master_if bus();
  dds_bus_wr_master #(.WR_ID(WR_ID), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_fixed(cmd_fixed), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .done_valid(done_valid), .done_resp(done_resp), .m(bus)
  );
  function automatic bit rnd(input int gap);
    return $urandom_range(0, 3) >= gap;
  endfunction
  task automatic idle_inputs();
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_fixed = 0; wr_data = 0; wr_valid = 0;
    bus.M_WR_ADDR_READY = 0; bus.M_WR_DATA_READY = 0; bus.M_WR_BACK_VALID = 0;
    bus.M_WR_BACK_ID = 0; bus.M_WR_BACK_RESP = 0;
  endtask
  task automatic do_burst(input logic [31:0] a, input logic [7:0] len, input bit fixed,
                          input logic [31:0] d0, input int gap, input logic [3:0] bid,
                          input logic [1:0] bresp, input int abort_beat, output int addr_cyc);
    logic [31:0] q[$];
    int src, beat, cyc;
    bit addr_done, back_done;
    logic [1:0] exp_resp;
    q.push_back(d0);
    for (int i = 1; i <= int'(len); i++) q.push_back($urandom);
    src = 0; beat = 0; cyc = 0; addr_done = 0; back_done = 0; addr_cyc = 0;
    exp_resp = (bid != WR_ID) ? 2'b10 : bresp;
    @(negedge clk);
    cmd_addr = a; cmd_len = len; cmd_fixed = fixed; cmd_valid = 1;
    #1 checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready: got %b want 1", cmd_ready); end
    while (!back_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_fixed = !fixed;
      wr_valid = src <= int'(len) && rnd(gap);
      if (src <= int'(len)) wr_data = q[src]; else wr_data = $urandom;
      bus.M_WR_ADDR_READY = rnd(gap);
      bus.M_WR_DATA_READY = rnd(gap);
      bus.M_WR_BACK_VALID = beat > int'(len) && rnd(gap);
      bus.M_WR_BACK_ID = bid; bus.M_WR_BACK_RESP = bresp;
      #1 checks++;
      if (done_valid !== 1'b0) begin errors++; $display("FAIL early_done: got %b want 0", done_valid); end
      if (bus.M_WR_ADDR_VALID) addr_cyc++;
      if (!addr_done) begin
        checks++;
        if (bus.M_WR_DATA_VALID !== 1'b0) begin errors++; $display("FAIL data_before_addr: got %b want 0", bus.M_WR_DATA_VALID); end
      end
      if (abort_beat >= 0 && beat == abort_beat) begin
        rst = 1;
        #1 checks++;
        if ({bus.M_WR_ADDR_VALID, bus.M_WR_DATA_VALID, bus.M_WR_DATA_LAST, bus.M_WR_BACK_READY, wr_ready, done_valid} !== 6'b0) begin
          errors++; $display("FAIL abort_outputs: got %b want 000000",
            {bus.M_WR_ADDR_VALID, bus.M_WR_DATA_VALID, bus.M_WR_DATA_LAST, bus.M_WR_BACK_READY, wr_ready, done_valid});
        end
        @(negedge clk);
        rst = 0; idle_inputs();
        #1 checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_cmd_ready: got %b want 1", cmd_ready); end
        repeat (4) begin
          @(negedge clk);
          #1 checks++;
          if (done_valid !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done_valid); end
        end
        return;
      end
      if (bus.M_WR_ADDR_VALID && bus.M_WR_ADDR_READY) begin
        addr_done = 1;
        checks++;
        if ({bus.M_WR_ADDR, bus.M_WR_ADDR_LEN, bus.M_WR_ADDR_BURST, bus.M_WR_ADDR_ID} !== {a, len, 1'b0, !fixed, WR_ID}) begin
          errors++; $display("FAIL addr_fields: got %h/%h/%b/%h want %h/%h/%b/%h", bus.M_WR_ADDR, bus.M_WR_ADDR_LEN,
            bus.M_WR_ADDR_BURST, bus.M_WR_ADDR_ID, a, len, {1'b0, !fixed}, WR_ID);
        end
      end
      if (bus.M_WR_DATA_VALID && bus.M_WR_DATA_READY) begin
        checks++;
        if (beat > int'(len)) begin
          errors++; $display("FAIL extra_beat: got beat %0d want at most %0d", beat, len);
        end else if ({bus.M_WR_DATA, bus.M_WR_DATA_LAST, bus.M_WR_STRB} !== {q[beat], beat == int'(len), 4'hF}) begin
          errors++; $display("FAIL beat%0d: got %h last=%b strb=%h want %h last=%b strb=f", beat, bus.M_WR_DATA,
            bus.M_WR_DATA_LAST, bus.M_WR_STRB, q[beat], beat == int'(len));
        end
        beat++;
      end
      if (wr_valid && wr_ready) src++;
      if (bus.M_WR_BACK_VALID && bus.M_WR_BACK_READY) back_done = 1;
    end
    checks++;
    if (!back_done || beat != int'(len) + 1) begin
      errors++; $display("FAIL burst_complete: got beats=%0d resp=%b want beats=%0d resp=1", beat, back_done, int'(len) + 1);
    end
    @(negedge clk);
    idle_inputs();
    #1 checks++;
    if ({done_valid, done_resp, cmd_ready} !== {1'b1, exp_resp, 1'b0}) begin
      errors++; $display("FAIL done_pulse: got v=%b r=%b rdy=%b want v=1 r=%b rdy=0", done_valid, done_resp, cmd_ready, exp_resp);
    end
    @(negedge clk);
    #1 checks++;
    if ({done_valid, done_resp, cmd_ready} !== {1'b0, exp_resp, 1'b1}) begin
      errors++; $display("FAIL done_hold: got v=%b r=%b rdy=%b want v=0 r=%b rdy=1", done_valid, done_resp, cmd_ready, exp_resp);
    end
  endtask
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1 checks++;
    if ({bus.M_WR_ADDR_VALID, bus.M_WR_DATA_VALID, bus.M_WR_DATA_LAST, bus.M_WR_BACK_READY, wr_ready, done_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
        {bus.M_WR_ADDR_VALID, bus.M_WR_DATA_VALID, bus.M_WR_DATA_LAST, bus.M_WR_BACK_READY, wr_ready, done_valid});
    end
    checks++;
    if ({bus.M_WR_ADDR, bus.M_WR_ADDR_LEN, bus.M_WR_ADDR_BURST, done_resp} !== 44'h0) begin
      errors++; $display("FAIL reset_regs: got %h/%h/%b/%b want 0", bus.M_WR_ADDR, bus.M_WR_ADDR_LEN, bus.M_WR_ADDR_BURST, done_resp);
    end
    @(negedge clk);
    rst = 0;
    #1 checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask
  task automatic test_single();
    int ac;
    do_burst(32'h4000_0001, 8'd0, 1'b0, 32'h0000_1234, 0, WR_ID, 2'b00, -1, ac);
    checks++;
    if (ac != 1) begin errors++; $display("FAIL single_addr_cycles: got %0d want 1", ac); end
  endtask
  task automatic test_incr_gaps();
    int ac;
    do_burst(32'h4000_000A, 8'd3, 1'b0, $urandom, 1, WR_ID, 2'b00, -1, ac);
    do_burst(32'h4000_000A, 8'd3, 1'b1, $urandom, 1, WR_ID, 2'b00, -1, ac);
  endtask
  task automatic test_slave_err();
    int ac;
    do_burst($urandom, 8'd1, 1'b0, $urandom, 0, WR_ID, 2'b10, -1, ac);
    do_burst($urandom, 8'd2, 1'b0, $urandom, 1, 4'h5, 2'b00, -1, ac);
  endtask
  task automatic test_random();
    int ac;
    logic [3:0] bid;
    for (int i = 0; i < 12; i++) begin
      bid = $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 15)) : WR_ID;
      do_burst($urandom, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
               int'($urandom_range(0, 1)), bid, $urandom_range(0, 1) ? 2'b10 : 2'b00, -1, ac);
    end
  endtask
  task automatic test_long();
    int ac;
    do_burst($urandom, 8'd255, 1'b1, $urandom, 0, WR_ID, 2'b00, -1, ac);
  endtask
  task automatic test_reset_mid_burst();
    int ac;
    do_burst(32'h4000_0100, 8'd7, 1'b0, $urandom, 0, WR_ID, 2'b00, 2, ac);
    do_burst(32'h4000_0200, 8'd2, 1'b0, $urandom, 1, WR_ID, 2'b00, -1, ac);
  endtask
  task automatic test_timeout();
    int n;
    int ac;
    idle_inputs();
    @(negedge clk);
    cmd_addr = 32'h4000_0300; cmd_len = 8'd1; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
`ifdef DDS_WR_TIMEOUT_EN
    n = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1 if (done_valid) break;
      if (bus.M_WR_ADDR_VALID) n++;
    end
    checks++;
    if ({done_valid, done_resp, bus.M_WR_ADDR_VALID, cmd_ready} !== {1'b1, 2'b11, 1'b0, 1'b0} || n != TMO) begin
      errors++; $display("FAIL timeout: got v=%b r=%b av=%b cycles=%0d want v=1 r=11 av=0 cycles=%0d",
        done_valid, done_resp, bus.M_WR_ADDR_VALID, n, TMO);
    end
    @(negedge clk);
    #1 checks++;
    if ({done_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL timeout_after: got %b want 01", {done_valid, cmd_ready}); end
`else
    n = 0;
    repeat (40) begin
      @(negedge clk);
      #1 if (bus.M_WR_ADDR_VALID && !done_valid) n++;
    end
    checks++;
    if (n != 40) begin errors++; $display("FAIL no_timeout_hold: got %0d want 40", n); end
    rst = 1;
    @(negedge clk);
    rst = 0;
`endif
    do_burst(32'h4000_0400, 8'd1, 1'b0, $urandom, 0, WR_ID, 2'b00, -1, ac);
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_incr_gaps();
    test_slave_err();
    test_random();
    test_long();
    test_reset_mid_burst();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
